// File: rtl/bc_pkg.sv
// Shared types and sizing helpers for the Bulls and Cows guess scorer.
package bc_pkg;

  localparam int unsigned NDIGITS_DEF = 4;

  typedef logic [3:0] bc_digit_t;

  typedef enum logic [1:0] {
    ENTRY  = 2'd0,
    SCORE  = 2'd1,
    RESULT = 2'd2,
    OVER   = 2'd3
  } bc_state_e;

  // Bits needed to hold a count in 0..n.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bc_guess_scorer_if.sv
// Key-strobe inputs and score/status outputs of the guess scorer.
interface bc_guess_scorer_if #(
  parameter int unsigned NDIGITS = bc_pkg::NDIGITS_DEF
);
  localparam int unsigned CW = bc_pkg::cnt_w(NDIGITS);

  logic                   key_valid;
  bc_pkg::bc_digit_t      key_digit;
  logic                   backspace;
  logic                   enter;
  logic                   new_game;
  logic [4*NDIGITS-1:0]   secret;

  logic [4*NDIGITS-1:0]   guess;
  logic [CW-1:0]          digit_count;
  logic                   busy;
  logic                   result_valid;
  logic [CW-1:0]          bulls;
  logic [CW-1:0]          cows;
  logic [7:0]             attempts;
  logic                   win;
  logic                   game_over;
  logic                   dup_err;
  logic                   short_err;

  modport master (
    output key_valid, key_digit, backspace, enter, new_game, secret,
    input  guess, digit_count, busy, result_valid, bulls, cows, attempts,
           win, game_over, dup_err, short_err
  );

  modport slave (
    input  key_valid, key_digit, backspace, enter, new_game, secret,
    output guess, digit_count, busy, result_valid, bulls, cows, attempts,
           win, game_over, dup_err, short_err
  );
endinterface

// File: rtl/bc_digit_matcher.sv
// Compares one guess digit at position idx against every secret digit.
module bc_digit_matcher import bc_pkg::*; #(
  parameter int unsigned NDIGITS = NDIGITS_DEF,
  parameter int unsigned IW      = 2
) (
  input  bc_digit_t            digit,
  input  logic [IW-1:0]        idx,
  input  logic [4*NDIGITS-1:0] secret,
  output logic                 is_bull,
  output logic                 is_cow
);

  always_comb begin
    is_bull = 1'b0;
    is_cow  = 1'b0;
    for (int j = 0; j < int'(NDIGITS); j++) begin
      if (secret[4*(int'(NDIGITS)-1-j) +: 4] == digit) begin
        if (IW'(j) == idx) is_bull = 1'b1;
        else               is_cow  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bc_guess_scorer.sv
// Guess entry with duplicate rejection, sequential bulls/cows scoring, and game tracking.
module bc_guess_scorer import bc_pkg::*; #(
  parameter int unsigned NDIGITS      = NDIGITS_DEF,
  parameter int unsigned MAX_ATTEMPTS = 10
) (
  input  logic              clk,
  input  logic              rst,
  bc_guess_scorer_if.slave  bus
);

  localparam int unsigned CW = cnt_w(NDIGITS);
  localparam int unsigned IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int unsigned GW = 4 * NDIGITS;

  bc_state_e       state_q, state_d;
  logic [GW-1:0]   guess_q, guess_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [GW-1:0]   sec_q, sec_d;
  logic [CW-1:0]   bacc_q, bacc_d, cacc_q, cacc_d;
  logic [CW-1:0]   bulls_q, bulls_d, cows_q, cows_d;
  logic [7:0]      att_q, att_d;
  logic            win_q, win_d, over_q, over_d;
  logic            busy_q, busy_d, rv_q, rv_d;
  logic            dup_q, dup_d, short_q, short_d;

  bc_digit_t       cur_digit;
  logic            is_bull, is_cow;
  logic            in_guess;
  logic [CW-1:0]   bulls_fin, cows_fin;
  logic [7:0]      att_inc;

  // Digit under scoring and duplicate lookup against the entered prefix.
  always_comb begin
    cur_digit = '0;
    in_guess  = 1'b0;
    for (int p = 0; p < int'(NDIGITS); p++) begin
      if (IW'(p) == idx_q) cur_digit = guess_q[4*(int'(NDIGITS)-1-p) +: 4];
      if ((CW'(p) < cnt_q) && (guess_q[4*(int'(NDIGITS)-1-p) +: 4] == bus.key_digit))
        in_guess = 1'b1;
    end
  end

  bc_digit_matcher #(.NDIGITS(NDIGITS), .IW(IW)) u_matcher (
    .digit   (cur_digit),
    .idx     (idx_q),
    .secret  (sec_q),
    .is_bull (is_bull),
    .is_cow  (is_cow)
  );

  assign bulls_fin = bacc_q + CW'(is_bull);
  assign cows_fin  = cacc_q + CW'(is_cow);
  assign att_inc   = (att_q == 8'hFF) ? att_q : att_q + 8'd1;

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    guess_d = guess_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sec_d   = sec_q;
    bacc_d  = bacc_q;
    cacc_d  = cacc_q;
    bulls_d = bulls_q;
    cows_d  = cows_q;
    att_d   = att_q;
    win_d   = win_q;
    over_d  = over_q;
    rv_d    = 1'b0;
    dup_d   = 1'b0;
    short_d = 1'b0;

    if (bus.new_game) begin
      state_d = ENTRY;
      guess_d = '0;
      cnt_d   = '0;
      idx_d   = '0;
      sec_d   = '0;
      bacc_d  = '0;
      cacc_d  = '0;
      bulls_d = '0;
      cows_d  = '0;
      att_d   = '0;
      win_d   = 1'b0;
      over_d  = 1'b0;
    end else begin
      unique case (state_q)
        ENTRY: begin
          if (bus.enter) begin
            if (cnt_q == CW'(NDIGITS)) begin
              sec_d   = bus.secret;
              bacc_d  = '0;
              cacc_d  = '0;
              idx_d   = '0;
              state_d = SCORE;
            end else begin
              short_d = 1'b1;
            end
          end else if (bus.backspace) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - CW'(1);
              for (int p = 0; p < int'(NDIGITS); p++)
                if (CW'(p + 1) == cnt_q) guess_d[4*(int'(NDIGITS)-1-p) +: 4] = '0;
            end
          end else if (bus.key_valid) begin
            if ((bus.key_digit <= 4'd9) && !in_guess && (cnt_q < CW'(NDIGITS))) begin
              cnt_d = cnt_q + CW'(1);
              for (int p = 0; p < int'(NDIGITS); p++)
                if (CW'(p) == cnt_q) guess_d[4*(int'(NDIGITS)-1-p) +: 4] = bus.key_digit;
            end else begin
              dup_d = 1'b1;
            end
          end
        end

        SCORE: begin
          bacc_d = bulls_fin;
          cacc_d = cows_fin;
          idx_d  = idx_q + IW'(1);
          // Final position: publish so results are visible during RESULT.
          if (idx_q == IW'(NDIGITS - 1)) begin
            state_d = RESULT;
            idx_d   = '0;
            bulls_d = bulls_fin;
            cows_d  = cows_fin;
            att_d   = att_inc;
            rv_d    = 1'b1;
            win_d   = (bulls_fin == CW'(NDIGITS));
            over_d  = (bulls_fin == CW'(NDIGITS)) || (att_inc == 8'(MAX_ATTEMPTS));
          end
        end

        RESULT: begin
          guess_d = '0;
          cnt_d   = '0;
          state_d = over_q ? OVER : ENTRY;
        end

        OVER: begin
          state_d = OVER;
        end

        default: state_d = ENTRY;
      endcase
    end

    busy_d = (state_d == SCORE) || (state_d == RESULT);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ENTRY;
      guess_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      sec_q   <= '0;
      bacc_q  <= '0;
      cacc_q  <= '0;
      bulls_q <= '0;
      cows_q  <= '0;
      att_q   <= '0;
      win_q   <= 1'b0;
      over_q  <= 1'b0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
      dup_q   <= 1'b0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      guess_q <= guess_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sec_q   <= sec_d;
      bacc_q  <= bacc_d;
      cacc_q  <= cacc_d;
      bulls_q <= bulls_d;
      cows_q  <= cows_d;
      att_q   <= att_d;
      win_q   <= win_d;
      over_q  <= over_d;
      busy_q  <= busy_d;
      rv_q    <= rv_d;
      dup_q   <= dup_d;
      short_q <= short_d;
    end
  end

  assign bus.guess        = guess_q;
  assign bus.digit_count  = cnt_q;
  assign bus.busy         = busy_q;
  assign bus.result_valid = rv_q;
  assign bus.bulls        = bulls_q;
  assign bus.cows         = cows_q;
  assign bus.attempts     = att_q;
  assign bus.win          = win_q;
  assign bus.game_over    = over_q;
  assign bus.dup_err      = dup_q;
  assign bus.short_err    = short_q;

endmodule

// File: tb/tb_bc_guess_scorer.sv
// Directed scoreboard bench for bc_guess_scorer (NDIGITS=4, MAX_ATTEMPTS=2).
module tb_bc_guess_scorer;

  typedef struct {
    int b;
    int c;
    int a;
    int w;
    int o;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  res_t exp_q[$];
  int   err_q[$];

  bc_guess_scorer_if #(.NDIGITS(4)) bus ();

  bc_guess_scorer #(.NDIGITS(4), .MAX_ATTEMPTS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops expected results and error strobes as the DUT presents them.
  always @(negedge clk) begin
    res_t r;
    int   kind;
    if (bus.result_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result: got result_valid=1 expected none");
      end else begin
        r = exp_q.pop_front();
        check("bulls",     longint'(bus.bulls),     longint'(r.b));
        check("cows",      longint'(bus.cows),      longint'(r.c));
        check("attempts",  longint'(bus.attempts),  longint'(r.a));
        check("win",       longint'(bus.win),       longint'(r.w));
        check("game_over", longint'(bus.game_over), longint'(r.o));
      end
    end
    if (bus.dup_err === 1'b1 || bus.short_err === 1'b1) begin
      kind = (bus.dup_err ? 1 : 0) + (bus.short_err ? 2 : 0);
      if (err_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_err: got kind %0d expected none", kind);
      end else begin
        check("err_kind", longint'(kind), longint'(err_q.pop_front()));
      end
    end
  end

  task automatic press(input logic [3:0] d);
    bus.key_valid = 1'b1; bus.key_digit = d;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  task automatic keys4(input logic [15:0] v);
    for (int i = 3; i >= 0; i--) press(v[4*i +: 4]);
  endtask

  task automatic bksp();
    bus.backspace = 1'b1;
    @(negedge clk);
    bus.backspace = 1'b0;
  endtask

  task automatic pulse_enter();
    bus.enter = 1'b1;
    @(negedge clk);
    bus.enter = 1'b0;
  endtask

  task automatic ng();
    bus.new_game = 1'b1;
    @(negedge clk);
    bus.new_game = 1'b0;
  endtask

  task automatic check_idle(input string nm);
    check({nm, "_guess"},    longint'(bus.guess),       0);
    check({nm, "_count"},    longint'(bus.digit_count), 0);
    check({nm, "_bulls"},    longint'(bus.bulls),       0);
    check({nm, "_cows"},     longint'(bus.cows),        0);
    check({nm, "_attempts"}, longint'(bus.attempts),    0);
    check({nm, "_flags"},
          longint'({bus.busy, bus.result_valid, bus.win, bus.game_over, bus.dup_err, bus.short_err}), 0);
  endtask

  // Called at the negedge of cycle E+1; follows scoring to the return to entry.
  task automatic fin_result();
    int n;
    check("busy_e1", longint'(bus.busy), 1);
    n = 1;
    while (bus.result_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("result_latency", longint'(n), 5);
    @(negedge clk);
    check("post_busy",  longint'(bus.busy),        0);
    check("post_count", longint'(bus.digit_count), 0);
    check("post_guess", longint'(bus.guess),       0);
  endtask

  task automatic submit(input int b, input int c, input int a, input int w, input int o);
    exp_q.push_back('{b: b, c: c, a: a, w: w, o: o});
    pulse_enter();
    fin_result();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.key_valid = 1'b0; bus.key_digit = '0; bus.backspace = 1'b0;
    bus.enter = 1'b0; bus.new_game = 1'b0; bus.secret = 16'h1234;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_idle("reset");

    // Exact guess wins and ends the game.
    keys4(16'h1234);
    check("entry_guess", longint'(bus.guess),       16'h1234);
    check("entry_count", longint'(bus.digit_count), 4);
    submit(4, 0, 1, 1, 1);
    check("win_held",  longint'(bus.win),       1);
    check("over_held", longint'(bus.game_over), 1);
    press(4'd5);
    check("over_key_ignored", longint'(bus.digit_count), 0);
    ng();
    check_idle("new_game1");

    // All cows, game continues.
    keys4(16'h4321);
    submit(0, 4, 1, 0, 0);
    check("cows_win",  longint'(bus.win),       0);
    check("cows_over", longint'(bus.game_over), 0);

    // Reset during the second scoring cycle aborts the result.
    keys4(16'h1234);
    pulse_enter();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("rst_score");
    repeat (8) @(negedge clk);

    // Duplicate, invalid code and overflow rejection.
    ng();
    press(4'd5);
    err_q.push_back(1);
    press(4'd5);
    check("dup_guess", longint'(bus.guess),       16'h5000);
    check("dup_count", longint'(bus.digit_count), 1);
    err_q.push_back(1);
    press(4'hA);
    check("bad_code_count", longint'(bus.digit_count), 1);
    press(4'd6); press(4'd7); press(4'd8);
    check("full_guess", longint'(bus.guess), 16'h5678);
    err_q.push_back(1);
    press(4'd9);
    check("overflow_guess", longint'(bus.guess),       16'h5678);
    check("overflow_count", longint'(bus.digit_count), 4);

    // Backspace and short enter.
    repeat (4) bksp();
    check("bksp_all_guess", longint'(bus.guess), 0);
    bksp();
    check("bksp_zero_count", longint'(bus.digit_count), 0);
    press(4'd7); press(4'd8); bksp();
    check("bksp_guess", longint'(bus.guess),       16'h7000);
    check("bksp_count", longint'(bus.digit_count), 1);
    err_q.push_back(2);
    pulse_enter();
    check("short_count", longint'(bus.digit_count), 1);
    check("short_busy",  longint'(bus.busy),        0);

    // Attempt limit reached with misses.
    ng();
    keys4(16'h5678);
    submit(0, 0, 1, 0, 0);
    keys4(16'h5678);
    submit(0, 0, 2, 0, 1);
    check("limit_over", longint'(bus.game_over), 1);
    check("limit_win",  longint'(bus.win),       0);
    press(4'd1);
    check("limit_key_ignored", longint'(bus.digit_count), 0);
    pulse_enter();
    ng();
    check_idle("new_game2");

    // Enter outranks a simultaneous key; secret change mid-score has no effect.
    keys4(16'h1243);
    exp_q.push_back('{b: 2, c: 2, a: 1, w: 0, o: 0});
    bus.enter = 1'b1; bus.key_valid = 1'b1; bus.key_digit = 4'd5;
    @(negedge clk);
    bus.enter = 1'b0; bus.key_valid = 1'b0;
    bus.secret = 16'h9876;
    fin_result();
    bus.secret = 16'h1234;

    repeat (3) @(negedge clk);
    check("res_queue_empty", longint'(exp_q.size()), 0);
    check("err_queue_empty", longint'(err_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
